// File: rtl/send_req_arbiter.sv
// ---------------------------------------------------------------------------
// send_req_arbiter
//
// Shares one send_controller between NUM_REQ local requesters (DMA/host send
// queues). A pending request is picked round-robin while the arbiter is idle.
// Its address/DFX fields are captured into the router_* outputs. The arbiter
// then raises router_start_req as a level and holds it until router_send_done.
// Completion is reported to the winner. After every transaction
// router_start_req stays low for at least three cycles, so the send_controller's
// rising-edge detect fires exactly once per request.
//
// Optional feature macro: SEND_ARB_TIMEOUT_EN
//   defined   : a WAIT_DONE watchdog aborts a transaction after TIMEOUT_CYCLES
//               cycles without router_send_done and pulses req_timeout.
//   undefined : no watchdog; WAIT_DONE waits indefinitely and req_timeout is 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         per-requester pending request (sampled only in IDLE)
//   req_src_addr      packed source addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_dst_addr      packed destination addresses
//   req_dst_dfx       packed destination DFX ids
//   local_dfx         this router's DFX id, forwarded as source DFX
//   req_ready         one-cycle accept pulse to the winner
//   req_done          one-cycle completion pulse to the winner
//   req_timeout       one-cycle abort pulse (0 without the watchdog)
//   router_start_req  level request to the send_controller
//   router_scr_addr   captured source address
//   router_dst_addr   captured destination address
//   router_src_dfx    captured source DFX (local_dfx)
//   router_dst_dfx    captured destination DFX
//   router_send_done  completion from the send_controller
//   grant_id          index of the current or last winner
//   busy              high in every state except IDLE
// ---------------------------------------------------------------------------
module send_req_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DFX_WIDTH      = 2,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_dst_addr,
  input  logic [NUM_REQ*DFX_WIDTH-1:0]    req_dst_dfx,
  input  logic [DFX_WIDTH-1:0]            local_dfx,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [NUM_REQ-1:0]              req_timeout,
  output logic                            router_start_req,
  output logic [ADDR_WIDTH-1:0]           router_scr_addr,
  output logic [ADDR_WIDTH-1:0]           router_dst_addr,
  output logic [DFX_WIDTH-1:0]            router_src_dfx,
  output logic [DFX_WIDTH-1:0]            router_dst_dfx,
  input  logic                            router_send_done,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]      req_done_q, req_done_d;
  logic                    start_q, start_d;
  logic [ADDR_WIDTH-1:0]   src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
  logic [DFX_WIDTH-1:0]    src_dfx_q, src_dfx_d;
  logic [DFX_WIDTH-1:0]    dst_dfx_q, dst_dfx_d;
  logic                    busy_q, busy_d;

  // Unpacked views of the packed per-requester fields.
  logic [ADDR_WIDTH-1:0]   src_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   dst_arr [NUM_REQ];
  logic [DFX_WIDTH-1:0]    dfx_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign src_arr[gi] = req_src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dst_arr[gi] = req_dst_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dfx_arr[gi] = req_dst_dfx[gi*DFX_WIDTH +: DFX_WIDTH];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin winner: first valid requester searching upward from
  // last_grant+1 with wrap-around. The modulo keeps non-power-of-two
  // NUM_REQ correct.
  // -------------------------------------------------------------------------
  logic          any_valid;
  logic          found;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  int            idx;

  always_comb begin
    any_valid = |req_valid;
    found     = 1'b0;
    winner    = last_grant_q;
    cand      = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant_q) + k) % NUM_REQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef SEND_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]      wd_cnt_q, wd_cnt_d;
  logic [NUM_REQ-1:0] req_timeout_q, req_timeout_d;
`else
  // The limit only matters when the watchdog is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    req_ready_d  = '0;
    req_done_d   = '0;
    start_d      = start_q;
    src_addr_d   = src_addr_q;
    dst_addr_d   = dst_addr_q;
    src_dfx_d    = src_dfx_q;
    dst_dfx_d    = dst_dfx_q;
`ifdef SEND_ARB_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    req_timeout_d = '0;
`endif

    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        if (any_valid) begin
          src_addr_d          = src_arr[winner];
          dst_addr_d          = dst_arr[winner];
          dst_dfx_d           = dfx_arr[winner];
          src_dfx_d           = local_dfx;
          last_grant_d        = winner;
          grant_id_d          = winner;
          req_ready_d[winner] = 1'b1;
          state_d             = S_ISSUE;
        end
      end

      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_WAIT_DONE;
`ifdef SEND_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end

      S_WAIT_DONE: begin
        if (router_send_done) begin
          // Done takes precedence over a watchdog expiring in the same cycle.
          req_done_d[grant_id_q] = 1'b1;
          start_d                = 1'b0;
          state_d                = S_RELEASE;
        end
`ifdef SEND_ARB_TIMEOUT_EN
        // Counter holds 0 on the first WAIT_DONE cycle, so the abort pulse
        // appears TIMEOUT_CYCLES cycles after entering WAIT_DONE.
        else if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_timeout_d[grant_id_q] = 1'b1;
          start_d                   = 1'b0;
          state_d                   = S_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end

      S_RELEASE: begin
        // Guaranteed low cycle so the next request produces a fresh rising edge.
        start_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      req_ready_q  <= '0;
      req_done_q   <= '0;
      start_q      <= 1'b0;
      src_addr_q   <= '0;
      dst_addr_q   <= '0;
      src_dfx_q    <= '0;
      dst_dfx_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      req_ready_q  <= req_ready_d;
      req_done_q   <= req_done_d;
      start_q      <= start_d;
      src_addr_q   <= src_addr_d;
      dst_addr_q   <= dst_addr_d;
      src_dfx_q    <= src_dfx_d;
      dst_dfx_q    <= dst_dfx_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SEND_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= '0;
      req_timeout_q <= '0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      req_timeout_q <= req_timeout_d;
    end
  end

  assign req_timeout = req_timeout_q;
`else
  assign req_timeout = '0;
`endif

  assign req_ready        = req_ready_q;
  assign req_done         = req_done_q;
  assign router_start_req = start_q;
  assign router_scr_addr  = src_addr_q;
  assign router_dst_addr  = dst_addr_q;
  assign router_src_dfx   = src_dfx_q;
  assign router_dst_dfx   = dst_dfx_q;
  assign grant_id         = grant_id_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_send_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_send_req_arbiter
//
// Bench for send_req_arbiter (4 requesters, 10-bit addresses, 2-bit DFX,
// TIMEOUT_CYCLES=8). A vector table drives the round-robin transactions.
// A scoreboard queue holds the grant expected from each driven request. A
// monitor pops it whenever req_ready pulses. Hand-written sequences cover the
// ignored-done, watchdog/no-watchdog and asynchronous reset cases.
// ---------------------------------------------------------------------------
module tb_send_req_arbiter;

  localparam int AW = 10;
  localparam int DW = 2;
  localparam int NR = 4;
  localparam int GW = 2;
  localparam int TO = 8;

  logic               clk;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR*AW-1:0]   req_src_addr;
  logic [NR*AW-1:0]   req_dst_addr;
  logic [NR*DW-1:0]   req_dst_dfx;
  logic [DW-1:0]      local_dfx;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0]      req_done;
  logic [NR-1:0]      req_timeout;
  logic               router_start_req;
  logic [AW-1:0]      router_scr_addr;
  logic [AW-1:0]      router_dst_addr;
  logic [DW-1:0]      router_src_dfx;
  logic [DW-1:0]      router_dst_dfx;
  logic               router_send_done;
  logic [GW-1:0]      grant_id;
  logic               busy;

  send_req_arbiter #(
    .ADDR_WIDTH     (AW),
    .DFX_WIDTH      (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_src_addr     (req_src_addr),
    .req_dst_addr     (req_dst_addr),
    .req_dst_dfx      (req_dst_dfx),
    .local_dfx        (local_dfx),
    .req_ready        (req_ready),
    .req_done         (req_done),
    .req_timeout      (req_timeout),
    .router_start_req (router_start_req),
    .router_scr_addr  (router_scr_addr),
    .router_dst_addr  (router_dst_addr),
    .router_src_dfx   (router_src_dfx),
    .router_dst_dfx   (router_dst_dfx),
    .router_send_done (router_send_done),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NR-1:0] valid;
    int            delay;
    int            exp_g;
  } vec_t;

  typedef struct {
    int            g;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] ddfx;
    logic [DW-1:0] sdfx;
  } exp_t;

  exp_t ready_q[$];
  int   done_q[$];

  logic [AW-1:0] src_tab [NR];
  logic [AW-1:0] dst_tab [NR];
  logic [DW-1:0] dfx_tab [NR];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Monitor: pops the scoreboard on each req_ready / req_done pulse and
  // checks the low gap between router_start_req rising edges.
  // -------------------------------------------------------------------------
  logic prev_start = 1'b0;
  int   low_cnt    = 0;
  bit   seen_rise  = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_start = 1'b0;
      low_cnt    = 0;
      seen_rise  = 1'b0;
    end else begin
      if (req_ready != '0) begin
        if (ready_q.size() == 0) begin
          chk("ready_unexpected", 32'(req_ready), 32'd0);
        end else begin
          exp_t e;
          e = ready_q.pop_front();
          chk("ready_onehot", 32'(req_ready), 32'd1 << e.g);
          chk("grant_id", 32'(grant_id), 32'(e.g));
          chk("src_addr", 32'(router_scr_addr), 32'(e.src));
          chk("dst_addr", 32'(router_dst_addr), 32'(e.dst));
          chk("dst_dfx", 32'(router_dst_dfx), 32'(e.ddfx));
          chk("src_dfx", 32'(router_src_dfx), 32'(e.sdfx));
          $display("grant g=%0d src=%h dst=%h ddfx=%0d", grant_id, router_scr_addr,
                   router_dst_addr, router_dst_dfx);
        end
      end
      if (req_done != '0) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(req_done), 32'd0);
        end else begin
          int g;
          g = done_q.pop_front();
          chk("done_onehot", 32'(req_done), 32'd1 << g);
        end
      end
      if (router_start_req && !prev_start) begin
        if (seen_rise) chk("start_gap_ge3", 32'(low_cnt >= 3), 32'd1);
        seen_rise = 1'b1;
        low_cnt   = 0;
      end
      if (!router_start_req) low_cnt++;
      prev_start = router_start_req;
    end
  end

  // Request accepted: returns in the first WAIT_DONE cycle (start high).
  task automatic start_txn(input logic [NR-1:0] v, input int eg);
    exp_t e;
    int   lat;
    e.g    = eg;
    e.src  = src_tab[eg];
    e.dst  = dst_tab[eg];
    e.ddfx = dfx_tab[eg];
    e.sdfx = local_dfx;
    ready_q.push_back(e);
    req_valid = v;
    lat = 0;
    do begin
      step();
      lat++;
    end while (req_ready == '0 && lat < 10);
    chk("ready_latency", 32'(lat), 32'd1);
    req_valid = v & ~req_ready;
    step();
    chk("start_high", 32'(router_start_req), 32'd1);
    chk("busy_wait", 32'(busy), 32'd1);
  endtask

  // Full transaction: done driven `delay` cycles after start rises.
  task automatic run_txn(input logic [NR-1:0] v, input int delay, input int eg);
    start_txn(v, eg);
    repeat (delay) step();
    router_send_done = 1'b1;
    done_q.push_back(eg);
    step();
    router_send_done = 1'b0;
    chk("done_pulse", 32'(req_done), 32'd1 << eg);
    chk("start_fall", 32'(router_start_req), 32'd0);
    chk("busy_release", 32'(busy), 32'd1);
    req_valid = '0;
    step();
    chk("busy_idle", 32'(busy), 32'd0);
    $display("txn valid=%b grant=%0d delay=%0d done", v, eg, delay);
  endtask

  vec_t vecs [11];

  initial begin
    src_tab[0] = 10'h0A3; dst_tab[0] = 10'h04B; dfx_tab[0] = 2'd0;
    src_tab[1] = 10'h1C7; dst_tab[1] = 10'h2F0; dfx_tab[1] = 2'd2;
    src_tab[2] = 10'h155; dst_tab[2] = 10'h2AA; dfx_tab[2] = 2'd3;
    src_tab[3] = 10'h3E1; dst_tab[3] = 10'h11D; dfx_tab[3] = 2'd1;

    // valid, done delay, expected winner
    vecs[0]  = '{4'b1111, 5, 0};
    vecs[1]  = '{4'b1111, 1, 1};
    vecs[2]  = '{4'b1111, 3, 2};
    vecs[3]  = '{4'b1111, 2, 3};
    vecs[4]  = '{4'b1111, 4, 0};
    vecs[5]  = '{4'b0100, 5, 2};
    vecs[6]  = '{4'b0010, 0, 1};
    vecs[7]  = '{4'b1010, 3, 3};
    vecs[8]  = '{4'b1010, 1, 1};
    vecs[9]  = '{4'b1001, 2, 3};
    vecs[10] = '{4'b1001, 2, 0};

    rst_n            = 1'b0;
    req_valid        = '0;
    router_send_done = 1'b0;
    local_dfx        = 2'd1;
    for (int i = 0; i < NR; i++) begin
      req_src_addr[i*AW +: AW] = src_tab[i];
      req_dst_addr[i*AW +: AW] = dst_tab[i];
      req_dst_dfx[i*DW +: DW]  = dfx_tab[i];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 32'(router_start_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_src", 32'(router_scr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].valid, vecs[i].delay, vecs[i].exp_g);
    end

    // Done pulsed in IDLE and in ISSUE is ignored.
    router_send_done = 1'b1;
    step();
    router_send_done = 1'b0;
    chk("idle_done_ignored", 32'(req_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    begin
      exp_t e;
      e.g = 0; e.src = src_tab[0]; e.dst = dst_tab[0]; e.ddfx = dfx_tab[0]; e.sdfx = local_dfx;
      ready_q.push_back(e);
    end
    req_valid = 4'b0001;
    step();
    chk("ign_ready", 32'(req_ready), 32'd1);
    req_valid        = '0;
    router_send_done = 1'b1;
    step();
    router_send_done = 1'b0;
    chk("ign_start", 32'(router_start_req), 32'd1);
    chk("ign_no_done", 32'(req_done), 32'd0);
    step();
    chk("ign_still_wait", 32'(router_start_req), 32'd1);
    chk("ign_no_done2", 32'(req_done), 32'd0);
    step();
    router_send_done = 1'b1;
    done_q.push_back(0);
    step();
    router_send_done = 1'b0;
    chk("ign_done_late", 32'(req_done), 32'd1);
    step();
    step();
    chk("ign_idle", 32'(busy), 32'd0);
    $display("txn done ignored outside WAIT_DONE checked");

`ifdef SEND_ARB_TIMEOUT_EN
    start_txn(4'b0010, 1);
    for (int k = 1; k < TO; k++) begin
      step();
      chk("wd_no_timeout_yet", 32'(req_timeout), 32'd0);
    end
    step();
    chk("wd_timeout", 32'(req_timeout), 32'b0010);
    chk("wd_no_done", 32'(req_done), 32'd0);
    chk("wd_start_low", 32'(router_start_req), 32'd0);
    req_valid = '0;
    step();
    chk("wd_idle", 32'(busy), 32'd0);
    $display("txn watchdog timeout grant=1 checked");
    start_txn(4'b0100, 2);
`else
    start_txn(4'b0010, 1);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("no_wd_timeout", 32'(req_timeout), 32'd0);
    end
    chk("no_wd_start", 32'(router_start_req), 32'd1);
    chk("no_wd_busy", 32'(busy), 32'd1);
    $display("txn no watchdog: waits in WAIT_DONE");
`endif

    // Asynchronous reset in WAIT_DONE, between clock edges.
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(router_start_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant_id), 32'd0);
    chk("arst_dst", 32'(router_dst_addr), 32'd0);
    chk("arst_timeout", 32'(req_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(req_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("txn async reset in WAIT_DONE checked");
    run_txn(4'b1111, 2, 0);

    step();
    chk("ready_q_empty", 32'(ready_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
